ara_store_trace: RTL and testbench

// - Synthesizable store-trace capture for Ara. Snoops the VLSU AXI W channel and buffers each

---
 rtl/ara_store_trace_pkg.sv | 26 ++
 rtl/ara_store_trace_if.sv | 24 ++
 rtl/ara_store_trace_fifo.sv | 43 ++++
 rtl/ara_store_trace.sv | 128 ++++++++++++
 tb/tb_ara_store_trace.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ara_store_trace_pkg.sv
// Shared types for the Ara store-trace capture block: beat record, serializer
// states and the byte-lane priority helper.
package ara_store_trace_pkg;

  localparam int unsigned TraceDataWidth = 256;
  // Widest strobe the lane-index helper can scan (DataWidth up to 1024 bits).
  localparam int unsigned MaxStrbWidth   = 128;

  typedef struct packed {
    logic [TraceDataWidth-1:0]   data;
    logic [TraceDataWidth/8-1:0] strb;
  } trace_beat_t;

  typedef enum logic {
    StIdle,
    StShift
  } ser_state_e;

  function automatic logic [6:0] lowest_set_idx(input logic [MaxStrbWidth-1:0] mask);
    lowest_set_idx = '0;
    for (int i = MaxStrbWidth - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set_idx = 7'(i);
    end
  endfunction

endpackage

// File: rtl/ara_store_trace_if.sv
// Snooped AXI W channel plus the serialized byte stream of the store tracer.
interface ara_store_trace_if #(
  parameter int unsigned DataWidth = 256
) ();

  logic [DataWidth-1:0]   w_data;
  logic [DataWidth/8-1:0] w_strb;
  logic                   w_valid;
  logic                   w_ready;
  logic [7:0]             byte_data;
  logic                   byte_valid;
  logic                   byte_ready;

  modport master (
    output w_data, w_strb, w_valid, w_ready, byte_ready,
    input  byte_data, byte_valid
  );

  modport slave (
    input  w_data, w_strb, w_valid, w_ready, byte_ready,
    output byte_data, byte_valid
  );

endinterface

// File: rtl/ara_store_trace_fifo.sv
// Beat FIFO for the store tracer; pointers carry an extra wrap bit so full and
// empty come straight from registers.
module ara_store_trace_fifo
  import ara_store_trace_pkg::*;
#(
  parameter int unsigned Depth  = 16,
  parameter type         beat_t = trace_beat_t
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  beat_t wdata_i,
  input  logic  pop_i,
  output beat_t rdata_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0] wptr_q, rptr_q;
  beat_t         mem_q [Depth];

  assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i && !full_o) wptr_q <= wptr_q + 1'b1;
      if (pop_i && !empty_o) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ara_store_trace.sv
// Passive store-trace capture: buffers accepted VLSU W beats and streams their
// strobed bytes out one per cycle, lowest lane first.
module ara_store_trace
  import ara_store_trace_pkg::*;
#(
  parameter int unsigned DataWidth  = 256,
  parameter int unsigned DepthBeats = 16,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  ara_store_trace_if.slave    trace,
  output logic                overflow_o,
  output logic [CntWidth-1:0] drop_cnt_o,
  output logic [CntWidth-1:0] byte_cnt_o,
  output logic                empty_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxW      = (StrbWidth > 1) ? $clog2(StrbWidth) : 1;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
  } beat_t;

  logic                 push, push_drop;
  logic                 fifo_full, fifo_empty, fifo_pop;
  beat_t                fifo_wdata, fifo_rdata;

  ser_state_e           state_q, state_d;
  logic [DataWidth-1:0] cur_data_q, cur_data_d;
  logic [StrbWidth-1:0] cur_mask_q, cur_mask_d, mask_clr;
  logic [StrbWidth-1:0][7:0] cur_bytes;
  logic [IdxW-1:0]      idx;
  logic                 byte_valid, byte_fire;

  logic                 overflow_q;
  logic [CntWidth-1:0]  drop_cnt_q, byte_cnt_q;

  assign push       = en_i && trace.w_valid && trace.w_ready;
  // A full FIFO refuses the beat even if the serializer pops this cycle.
  assign push_drop  = push && fifo_full;
  assign fifo_wdata = '{data: trace.w_data, strb: trace.w_strb};

  ara_store_trace_fifo #(
    .Depth  (DepthBeats),
    .beat_t (beat_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign cur_bytes  = cur_data_q;
  assign idx        = IdxW'(lowest_set_idx(MaxStrbWidth'(cur_mask_q)));
  assign mask_clr   = cur_mask_q & ~(StrbWidth'(1) << idx);
  assign byte_valid = (state_q == StShift) && (cur_mask_q != '0);
  assign byte_fire  = byte_valid && trace.byte_ready;

  // Outputs depend only on registered state, never on byte_ready.
  assign trace.byte_valid = byte_valid;
  assign trace.byte_data  = cur_bytes[idx];

  always_comb begin
    state_d    = state_q;
    cur_data_d = cur_data_q;
    cur_mask_d = cur_mask_q;
    fifo_pop   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (cur_mask_q == '0) begin
          if (!fifo_empty) fifo_pop = 1'b1;
          else             state_d  = StIdle;
        end else if (trace.byte_ready) begin
          cur_mask_d = mask_clr;
          if (mask_clr == '0) begin
            if (!fifo_empty) fifo_pop = 1'b1;
            else             state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (fifo_pop) begin
      cur_data_d = fifo_rdata.data;
      cur_mask_d = fifo_rdata.strb;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cur_data_q <= '0;
      cur_mask_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_data_q <= cur_data_d;
      cur_mask_q <= cur_mask_d;
      if (push_drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CntWidth'(1);
      end
      if (byte_fire) byte_cnt_q <= byte_cnt_q + CntWidth'(1);
    end
  end

  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;
  assign byte_cnt_o = byte_cnt_q;
  assign empty_o    = fifo_empty && (state_q == StIdle);

endmodule

// File: tb/tb_ara_store_trace.sv
// Scoreboard bench for ara_store_trace: the driver queues the strobed bytes of
// every beat the model says is accepted; a negedge monitor pops and compares.
module tb_ara_store_trace;

  localparam int unsigned DW    = 256;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned Depth = 16;
  localparam int unsigned CW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          overflow;
  logic [CW-1:0] drop_cnt, byte_cnt;
  logic          empty;

  always #5 clk = ~clk;

  ara_store_trace_if #(.DataWidth(DW)) bus ();

  ara_store_trace #(
    .DataWidth  (DW),
    .DepthBeats (Depth),
    .CntWidth   (CW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .trace      (bus),
    .overflow_o (overflow),
    .drop_cnt_o (drop_cnt),
    .byte_cnt_o (byte_cnt),
    .empty_o    (empty)
  );

  int unsigned checks = 0;
  int unsigned passes = 0;
  logic [7:0]  exp_q[$];
  int unsigned exp_bytes = 0;
  int unsigned cyc = 0;
  int unsigned ready_mode = 0;
  int unsigned valid_cycles = 0;
  int unsigned last_hs_cyc = 0, prev_hs_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Consumer ready: 0 = stalled, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.byte_ready = 1'b0;
      1:       bus.byte_ready = 1'b1;
      default: bus.byte_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.byte_valid === 1'b1) valid_cycles++;
      if (prev_stall) begin
        check("hold_valid", 64'(bus.byte_valid), 64'd1);
        check("hold_byte", 64'(bus.byte_data), 64'(prev_byte));
      end
      if (bus.byte_valid && bus.byte_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got %0h, expected no byte", bus.byte_data);
        end else begin
          exp_b = exp_q.pop_front();
          check("byte_stream", 64'(bus.byte_data), 64'(exp_b));
        end
        prev_hs_cyc = last_hs_cyc;
        last_hs_cyc = cyc;
      end
      prev_stall = bus.byte_valid && !bus.byte_ready;
      prev_byte  = bus.byte_data;
    end
  end

  // Reference model: an accepted beat contributes its strobed bytes, lowest lane first.
  task automatic model_accept(input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int i = 0; i < SW; i++) begin
      if (s[i]) begin
        exp_q.push_back(d[i*8 +: 8]);
        exp_bytes++;
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] s, input bit w_rdy,
                      input bit accepted);
    bus.w_data  = d;
    bus.w_strb  = s;
    bus.w_valid = 1'b1;
    bus.w_ready = w_rdy;
    if (accepted) model_accept(d, s);
    @(posedge clk);
    #1;
    bus.w_valid = 1'b0;
    bus.w_ready = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || empty !== 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < 3000), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    bit            w_rdy;
    int unsigned   nb;

    rst         = 1'b1;
    en          = 1'b1;
    bus.w_data  = '0;
    bus.w_strb  = '0;
    bus.w_valid = 1'b0;
    bus.w_ready = 1'b0;
    ready_mode  = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_byte_valid", 64'(bus.byte_valid), 64'd0);
    check("rst_byte", 64'(bus.byte_data), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_byte_cnt", 64'(byte_cnt), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);

    // Single beat, lanes 0 and 2: first byte visible two edges after the push.
    ready_mode = 1;
    d = rand_data();
    d[7:0]   = 8'hAA;
    d[23:16] = 8'hBB;
    send(d, 32'h0000_0005, 1'b1, 1'b1);
    @(negedge clk);
    check("latency_n1_valid", 64'(bus.byte_valid), 64'd0);
    @(negedge clk);
    check("latency_n2_valid", 64'(bus.byte_valid), 64'd1);
    check("latency_n2_byte", 64'(bus.byte_data), 64'hAA);
    wait_drain("single_drain");
    check("single_consecutive", 64'(last_hs_cyc - prev_hs_cyc), 64'd1);
    check("single_byte_cnt", 64'(byte_cnt), 64'd2);
    check("single_empty", 64'(empty), 64'd1);

    // Capture disabled: nothing enters the FIFO.
    en = 1'b0;
    for (int i = 0; i < 4; i++) send(rand_data(), '1, 1'b1, 1'b0);
    en = 1'b1;
    repeat (5) @(negedge clk);
    check("en0_byte_cnt", 64'(byte_cnt), 64'(exp_bytes));
    check("en0_drop_cnt", 64'(drop_cnt), 64'd0);
    check("en0_empty", 64'(empty), 64'd1);

    // Zero-strobe beat sandwiched between single-byte beats.
    valid_cycles = 0;
    send(rand_data(), 32'h1, 1'b1, 1'b1);
    send(rand_data(), 32'h0, 1'b1, 1'b1);
    send(rand_data(), 32'h1, 1'b1, 1'b1);
    wait_drain("zero_strb_drain");
    check("zero_strb_valid_cycles", 64'(valid_cycles), 64'd2);
    check("zero_strb_byte_cnt", 64'(byte_cnt), 64'(exp_bytes));

    // Random bursts with random consumer stalls; each burst fits in FIFO + serializer.
    ready_mode = 2;
    for (int b = 0; b < 8; b++) begin
      nb = $urandom_range(1, Depth);
      for (int i = 0; i < nb; i++) begin
        case ($urandom_range(0, 3))
          0:       s = '1;
          1:       s = '0;
          default: s = SW'($urandom());
        endcase
        w_rdy = ($urandom_range(0, 3) != 0);
        send(rand_data(), s, w_rdy, w_rdy);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
      wait_drain("rand_drain");
    end
    check("rand_byte_cnt", 64'(byte_cnt), 64'(exp_bytes));
    check("rand_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rand_overflow", 64'(overflow), 64'd0);

    // Overflow: consumer stalled, 20 back-to-back beats. The first beat moves into
    // the serializer, so Depth more fit in the FIFO and the remaining 3 are dropped.
    ready_mode = 0;
    for (int i = 0; i < 20; i++) send(rand_data(), '1, 1'b1, i < Depth + 1);
    @(negedge clk);
    check("ovf_overflow", 64'(overflow), 64'd1);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd3);
    check("ovf_pending_bytes", 64'(exp_q.size()), 64'((Depth + 1) * SW));
    ready_mode = 1;
    wait_drain("ovf_drain");
    check("ovf_byte_cnt", 64'(byte_cnt), 64'(exp_bytes));
    check("ovf_overflow_sticky", 64'(overflow), 64'd1);

    // Reset mid-stream with beats buffered discards everything.
    ready_mode = 0;
    for (int i = 0; i < 4; i++) send(rand_data(), '1, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_bytes = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_byte_valid", 64'(bus.byte_valid), 64'd0);
    check("mid_rst_byte_cnt", 64'(byte_cnt), 64'd0);
    check("mid_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    check("mid_rst_empty", 64'(empty), 64'd1);
    repeat (4) @(negedge clk);
    check("mid_rst_stays_empty", 64'(empty), 64'd1);

    // Normal operation resumes after the reset.
    ready_mode = 1;
    send(rand_data(), SW'($urandom()) | SW'(1), 1'b1, 1'b1);
    wait_drain("post_rst_drain");
    check("post_rst_byte_cnt", 64'(byte_cnt), 64'(exp_bytes));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
